// File: rtl/controlador_semaforos.sv
// ---------------------------------------------------------------------------
// controlador_semaforos
// Two-road traffic light sequencer. It drives the vehicular lights semaforo_A
// and semaforo_B, and their codes are also decoded downstream by the
// pedestrian controller.
// Sequence: A green -> A yellow -> (all red) -> B green -> B yellow ->
// (all red) -> A green.
// Road A is the main road. It keeps green until sensor_B reports a vehicle
// on road B, and only after the minimum A green time has elapsed.
//
// Optional feature:
//   Define CONTROLADOR_TODO_ROJO_EN to add the all-red clearance states
//   ROJO_AB and ROJO_BA, each lasting T_TODO_ROJO enabled cycles.
//   Without it, yellow hands over directly to the other road's green.
//
// Light encoding: 2'b10 green, 2'b01 yellow, 2'b00 red.
// ---------------------------------------------------------------------------
module controlador_semaforos #(
    parameter int T_VERDE_A   = 4,
    parameter int T_VERDE_B   = 3,
    parameter int T_AMARILLO  = 2,
    parameter int T_TODO_ROJO = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       sensor_B,
    output logic [1:0] semaforo_A,
    output logic [1:0] semaforo_B
);

    // Light codes shared by both roads
    localparam logic [1:0] LUZ_VERDE    = 2'b10;
    localparam logic [1:0] LUZ_AMARILLO = 2'b01;
    localparam logic [1:0] LUZ_ROJO     = 2'b00;

    // Index of each road in the per-road vectors
    localparam int ROAD_A = 0;
    localparam int ROAD_B = 1;

    // Last counter value of each phase (phase of T cycles ends at cnt = T-1)
    localparam logic [CNT_W-1:0] FIN_VERDE_A  = CNT_W'(T_VERDE_A - 1);
    localparam logic [CNT_W-1:0] FIN_VERDE_B  = CNT_W'(T_VERDE_B - 1);
    localparam logic [CNT_W-1:0] FIN_AMARILLO = CNT_W'(T_AMARILLO - 1);
`ifdef CONTROLADOR_TODO_ROJO_EN
    localparam logic [CNT_W-1:0] FIN_TODO_ROJO = CNT_W'(T_TODO_ROJO - 1);
`endif

    // Reject durations that cannot be represented by the phase counter.
    // T_TODO_ROJO is checked even when the all-red phases are not built, so
    // the same parameter set stays valid in both builds.
    localparam int DUR_MAX = (1 << CNT_W) - 1;
    if (T_VERDE_A < 1 || T_VERDE_A > DUR_MAX ||
        T_VERDE_B < 1 || T_VERDE_B > DUR_MAX ||
        T_AMARILLO < 1 || T_AMARILLO > DUR_MAX ||
        T_TODO_ROJO < 1 || T_TODO_ROJO > DUR_MAX) begin : g_duracion_invalida
        $error("controlador_semaforos: phase duration outside 1..2^CNT_W-1");
    end

`ifdef CONTROLADOR_TODO_ROJO_EN
    typedef enum logic [2:0] {
        A_VERDE    = 3'd0,
        A_AMARILLO = 3'd1,
        ROJO_AB    = 3'd2,
        B_VERDE    = 3'd3,
        B_AMARILLO = 3'd4,
        ROJO_BA    = 3'd5
    } estado_t;
`else
    typedef enum logic [2:0] {
        A_VERDE    = 3'd0,
        A_AMARILLO = 3'd1,
        B_VERDE    = 3'd3,
        B_AMARILLO = 3'd4
    } estado_t;
`endif

    estado_t          estado_reg;
    estado_t          estado_next;
    estado_t          estado_sig;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             fin_fase;

    // Per-road light flags derived from the next state, index ROAD_A/ROAD_B
    logic [1:0] verde_next;
    logic [1:0] amarillo_next;
    logic [1:0] luz_next [2];
    logic [1:0] luz_reg  [2];

    // Phase-end detection, successor state and counter update
    always_comb begin
        fin_fase    = 1'b0;
        estado_sig  = A_VERDE;
        estado_next = estado_reg;
        cnt_next    = cnt_reg;

        case (estado_reg)
            A_VERDE: begin
                fin_fase   = (cnt_reg >= FIN_VERDE_A) && sensor_B;
                estado_sig = A_AMARILLO;
            end
            A_AMARILLO: begin
                fin_fase   = (cnt_reg == FIN_AMARILLO);
`ifdef CONTROLADOR_TODO_ROJO_EN
                estado_sig = ROJO_AB;
`else
                estado_sig = B_VERDE;
`endif
            end
`ifdef CONTROLADOR_TODO_ROJO_EN
            ROJO_AB: begin
                fin_fase   = (cnt_reg == FIN_TODO_ROJO);
                estado_sig = B_VERDE;
            end
`endif
            B_VERDE: begin
                fin_fase   = (cnt_reg == FIN_VERDE_B);
                estado_sig = B_AMARILLO;
            end
            B_AMARILLO: begin
                fin_fase   = (cnt_reg == FIN_AMARILLO);
`ifdef CONTROLADOR_TODO_ROJO_EN
                estado_sig = ROJO_BA;
`else
                estado_sig = A_VERDE;
`endif
            end
`ifdef CONTROLADOR_TODO_ROJO_EN
            ROJO_BA: begin
                fin_fase   = (cnt_reg == FIN_TODO_ROJO);
                estado_sig = A_VERDE;
            end
`endif
            default: begin
                // Unreachable encodings fall back to the main-road green
                fin_fase   = 1'b1;
                estado_sig = A_VERDE;
            end
        endcase

        if (enb) begin
            if (fin_fase) begin
                estado_next = estado_sig;
                cnt_next    = '0;
            end else if (estado_reg == A_VERDE && cnt_reg >= FIN_VERDE_A) begin
                // Minimum A green reached: hold the count while waiting for B
                cnt_next = cnt_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // Decode the next state into per-road green/yellow flags
    always_comb begin
        verde_next    = 2'b00;
        amarillo_next = 2'b00;
        case (estado_next)
            A_VERDE:    verde_next[ROAD_A]    = 1'b1;
            A_AMARILLO: amarillo_next[ROAD_A] = 1'b1;
            B_VERDE:    verde_next[ROAD_B]    = 1'b1;
            B_AMARILLO: amarillo_next[ROAD_B] = 1'b1;
            default: begin
                verde_next    = 2'b00;
                amarillo_next = 2'b00;
            end
        endcase
    end

    // Assemble each road's light code from its flags
    for (genvar gi = 0; gi < 2; gi++) begin : g_luz
        assign luz_next[gi] = {verde_next[gi], amarillo_next[gi]};
    end

    // State, phase counter and registered light outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_reg      <= A_VERDE;
            cnt_reg         <= '0;
            luz_reg[ROAD_A] <= LUZ_VERDE;
            luz_reg[ROAD_B] <= LUZ_ROJO;
        end else begin
            estado_reg <= estado_next;
            cnt_reg    <= cnt_next;
            for (int i = 0; i < 2; i++) begin
                luz_reg[i] <= luz_next[i];
            end
        end
    end

    assign semaforo_A = luz_reg[ROAD_A];
    assign semaforo_B = luz_reg[ROAD_B];

    // Yellow code kept for readers of the encoding; the flags build it directly
    logic [1:0] luz_amarillo_ref;
    assign luz_amarillo_ref = LUZ_AMARILLO;
    logic unused_ok;
    assign unused_ok = ^luz_amarillo_ref;

endmodule

// File: tb/tb_controlador_semaforos.sv
// ---------------------------------------------------------------------------
// tb_controlador_semaforos
// Table-driven and hand-written sequences for controlador_semaforos.
// Expected light codes are pushed to a scoreboard queue when a stimulus is
// driven, then popped and compared one time unit after the clock edge.
// A monitor checks the safety invariant on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_controlador_semaforos;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enb = 1'b0;
    logic       sensor_B = 1'b0;
    logic [1:0] semaforo_A;
    logic [1:0] semaforo_B;

    int checks = 0;
    int passed = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       sen;
        logic [1:0] ea;
        logic [1:0] eb;
        string      nombre;
    } vec_t;

    typedef struct {
        string      nombre;
        logic [1:0] ea;
        logic [1:0] eb;
    } esperado_t;

    vec_t      tabla[$];
    esperado_t exp_q[$];

    // Expected {A,B} after each edge of a full cycle with sensor_B=1
    logic [3:0] exp_ciclo [14];

`ifdef CONTROLADOR_TODO_ROJO_EN
    localparam int EDGE_BV = 7;
`else
    localparam int EDGE_BV = 6;
`endif

    controlador_semaforos dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .sensor_B   (sensor_B),
        .semaforo_A (semaforo_A),
        .semaforo_B (semaforo_B)
    );

    always #5 clk = ~clk;

    // Safety invariant: never both roads non-red, never the unused code 11
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((semaforo_A != 2'b00 && semaforo_B != 2'b00) ||
                semaforo_A == 2'b11 || semaforo_B == 2'b11)
                $display("FAIL safety: semaforo_A=%b semaforo_B=%b, required at least one 00 and no 11",
                         semaforo_A, semaforo_B);
            else
                passed++;
        end
    end

    task automatic paso(input logic r, input logic e, input logic s,
                        input logic [1:0] ea, input logic [1:0] eb,
                        input string n);
        esperado_t got;
        @(negedge clk);
        reset    = r;
        enb      = e;
        sensor_B = s;
        exp_q.push_back('{n, ea, eb});
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        got = exp_q.pop_front();
        checks++;
        if (semaforo_A !== got.ea || semaforo_B !== got.eb)
            $display("FAIL %s: got A=%b B=%b, required A=%b B=%b",
                     got.nombre, semaforo_A, semaforo_B, got.ea, got.eb);
        else begin
            passed++;
            $display("ok   %s: A=%b B=%b", got.nombre, semaforo_A, semaforo_B);
        end
    endtask

    task automatic paso_ciclo(input int k, input string n);
        paso(1'b0, 1'b1, 1'b1, exp_ciclo[k][3:2], exp_ciclo[k][1:0],
             $sformatf("%s e%0d", n, k));
    endtask

    initial begin
`ifdef CONTROLADOR_TODO_ROJO_EN
        exp_ciclo = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100,
                      4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001,
                      4'b0000, 4'b1000};
`else
        exp_ciclo = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100,
                      4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b1000,
                      4'b1000, 4'b1000};
`endif

        // Reset state held for three edges, then a full cycle with sensor_B=1
        for (int i = 0; i < 3; i++)
            tabla.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 2'b00, $sformatf("reset r%0d", i)});
        for (int k = 1; k <= 13; k++)
            tabla.push_back('{1'b0, 1'b1, 1'b1, exp_ciclo[k][3:2], exp_ciclo[k][1:0],
                              $sformatf("ciclo e%0d", k)});
        for (int i = 0; i < tabla.size(); i++)
            paso(tabla[i].rst, tabla[i].en, tabla[i].sen, tabla[i].ea, tabla[i].eb, tabla[i].nombre);

        // Sensor wait: A holds green indefinitely, disabled edges ignore sensor
        paso(1'b1, 1'b1, 1'b0, 2'b10, 2'b00, "espera reset");
        for (int k = 1; k <= 20; k++)
            paso(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, $sformatf("espera e%0d", k));
        paso(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, "espera enb0 a");
        paso(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, "espera enb0 b");
        paso(1'b0, 1'b1, 1'b1, 2'b01, 2'b00, "espera e21");

        // Sensor pulse seen only on disabled edges is missed
        paso(1'b1, 1'b1, 1'b0, 2'b10, 2'b00, "pulso reset");
        for (int k = 1; k <= 4; k++)
            paso(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, $sformatf("pulso e%0d", k));
        paso(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, "pulso enb0 a");
        paso(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, "pulso enb0 b");
        paso(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, "pulso perdido");
        paso(1'b0, 1'b1, 1'b1, 2'b01, 2'b00, "pulso tomado");

        // Enable freeze one edge into B green
        paso(1'b1, 1'b1, 1'b1, 2'b10, 2'b00, "freeze reset");
        for (int k = 1; k <= EDGE_BV + 1; k++)
            paso_ciclo(k, "freeze");
        for (int k = 0; k < 5; k++)
            paso(1'b0, 1'b0, 1'(k & 1), 2'b00, 2'b10, $sformatf("freeze hold%0d", k));
        paso(1'b0, 1'b1, 1'b0, 2'b00, 2'b10, "freeze resume1");
        paso(1'b0, 1'b1, 1'b0, 2'b00, 2'b01, "freeze resume2");

        // Reset from B yellow, then the minimum A green again
        paso(1'b1, 1'b1, 1'b1, 2'b10, 2'b00, "reset midBamarillo");
        for (int k = 1; k <= 4; k++)
            paso_ciclo(k, "rearranque");

        // Reset wins over enb=0 while in A yellow
        paso(1'b1, 1'b0, 1'b0, 2'b10, 2'b00, "reset con enb0");
        paso(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, "tras reset enb0");

        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
